instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the instruction decode path. Accepts one symbolic instruction per handshake (mnemonic code plus operand fields).
- Encodes it into the 32-bit KGP-miniRISC word that the decoder consumes, then writes it sequentially into instruction memory from a base address.
- Sits between the bench or boot loader and the IMEM write port. Used to load programs before the core leaves reset.

Parameters:
ADDR_W, 10, IMEM word-address width; maximum program length is 2**ADDR_W words.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins a load session; ignored unless in IDLE or DONE
base_addr  in  ADDR_W  first IMEM word address, sampled on start
num_words  in  ADDR_W+1  number of words to load, sampled on start
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept
in_mnem  in  5  mnemonic code, enumerated in the package (0..22; 23..31 illegal)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_shamt  in  5  shift amount
in_imm  in  26  imm16 (signed, in [15:0]) or branch target26
imem_we  out  1  IMEM write strobe
imem_addr  out  ADDR_W  IMEM write address
imem_wdata  out  32  encoded word
busy  out  1  session active (LOAD or WRITE)
done  out  1  session complete; held until next start
words_written  out  ADDR_W+1  count of words committed this session
err_illegal  out  1  sticky; illegal mnemonic seen
err_range  out  1  sticky; immediate out of range (only with the optional feature)
err_overflow  out  1  sticky; address would pass 2**ADDR_W-1

Behaviour:
- Reset:
  - State = IDLE.
  - Every output is 0: in_ready, imem_we, imem_addr, imem_wdata, busy, done, words_written and all error flags.
- Instruction formats:
  - R-type: op[31:26] rs[25:21] rt[20:16] shamt[15:11] 0[10:6] func[5:0].
  - I-arith (addi, compi): op, rs[25:21], func[20:16], imm[15:0].
  - lw/sw: op, rs, rt, imm16.
  - b/bl/bcy/bncy: op, target[25:0].
  - br: op, rs, zeros.
  - bltz/bz/bnz: op, rs, imm16.
  - diff: op, rs, rt, zeros.
- Opcode/func values:
  - add 0/0, comp 0/1, addi 1/0, compi 1/1, and 10/0, xor 10/1.
  - shll 20/0, shrl 20/1, shra 20/2, shllv 21/0, shrlv 21/1, shrav 21/2.
  - lw 30, sw 31, b 40, bl 41, bcy 42, bncy 43, br 44, bltz 45, bz 46, bnz 47, diff 50.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE + start:
  - Clear words_written, errors and done.
  - Latch base_addr into the address pointer.
  - If num_words == 0, go to DONE; otherwise go to LOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready (cycle k), register the encoded word and address, then go to WRITE.
  - An illegal mnemonic sets err_illegal, writes nothing, leaves the counter unchanged and stays in LOAD.
- WRITE (cycle k+1):
  - imem_we = 1 for exactly one cycle; in_ready = 0.
  - Increment the pointer and words_written.
  - If words_written+1 == num_words, go to DONE; else go to LOAD.
  - Throughput is 1 word per 2 cycles.
- Overflow:
  - If a write has just used address 2**ADDR_W-1 and more words remain, set err_overflow and go to DONE.
  - There is no address wrap.
- start while busy is ignored.
- imem_wdata and imem_addr hold their last values outside WRITE.
- rst_n asserted mid-session aborts immediately. No partial write may occur; imem_we drops asynchronously.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined: for imm16 formats, in_imm[25:16] must all equal in_imm[15]. Otherwise set err_range, do not write, and stay in LOAD.
- Undefined: in_imm is silently truncated to [15:0]. err_range is tied to 0.

Decomposition:
- Package kgp_isa_pkg holds:
  - opcode and func constants, shared with the control unit;
  - the mnemonic enumeration;
  - the format-class type and the field-position constants.
- Sub-module instr_field_encoder is purely combinational: mnem/rs/rt/shamt/imm in, word, illegal and range_bad out. The FSM and counters stay in the top.

Test Plan:
- start base=0 num=1; add rs=3 rt=5 -> imem_we at k+1, addr 0, wdata 0x00650000, done=1, words_written=1.
- shra rs=2 shamt=4 at base=0x10 -> wdata 0x50402002, addr 0x10.
- lw rs=1 rt=2 imm=-4 followed by b target=0x100, num=2 -> writes 0x7822FFFC @0, then 0xA0000100 @1; in_ready low during each WRITE cycle.
- in_mnem=31 -> err_illegal=1, no imem_we, words_written unchanged; next legal word lands at the same address.
- With ENC_RANGE_CHECK_EN: addi imm=0x10000 -> err_range=1, no write. Without it: wdata imm field = 0x0000, write occurs.
- base=2**ADDR_W-1, num=2 -> one write, then err_overflow=1 and DONE. A separate run pulls rst_n low during WRITE -> all outputs 0 and no further imem_we.

Source files
------------

// File: rtl/kgp_isa_pkg.sv
// KGP-miniRISC ISA definitions shared by the instruction encoder and the control unit:
// opcodes, function codes, mnemonic enumeration, format classes and field positions.
package kgp_isa_pkg;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int SHAMT_LSB = 11;

    localparam logic [5:0] OP_ALU    = 6'd0;
    localparam logic [5:0] OP_ALUI   = 6'd1;
    localparam logic [5:0] OP_LOGIC  = 6'd10;
    localparam logic [5:0] OP_SHIFT  = 6'd20;
    localparam logic [5:0] OP_SHIFTV = 6'd21;
    localparam logic [5:0] OP_LW     = 6'd30;
    localparam logic [5:0] OP_SW     = 6'd31;
    localparam logic [5:0] OP_B      = 6'd40;
    localparam logic [5:0] OP_BL     = 6'd41;
    localparam logic [5:0] OP_BCY    = 6'd42;
    localparam logic [5:0] OP_BNCY   = 6'd43;
    localparam logic [5:0] OP_BR     = 6'd44;
    localparam logic [5:0] OP_BLTZ   = 6'd45;
    localparam logic [5:0] OP_BZ     = 6'd46;
    localparam logic [5:0] OP_BNZ    = 6'd47;
    localparam logic [5:0] OP_DIFF   = 6'd50;

    localparam logic [5:0] FN_ADD  = 6'd0;
    localparam logic [5:0] FN_COMP = 6'd1;
    localparam logic [5:0] FN_AND  = 6'd0;
    localparam logic [5:0] FN_XOR  = 6'd1;
    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd1;
    localparam logic [5:0] FN_SRA  = 6'd2;

    typedef enum logic [4:0] {
        MN_ADD, MN_COMP, MN_ADDI, MN_COMPI, MN_AND, MN_XOR,
        MN_SHLL, MN_SHRL, MN_SHRA, MN_SHLLV, MN_SHRLV, MN_SHRAV,
        MN_LW, MN_SW, MN_B, MN_BL, MN_BCY, MN_BNCY,
        MN_BR, MN_BLTZ, MN_BZ, MN_BNZ, MN_DIFF
    } mnem_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I_ARITH, FMT_MEM, FMT_JUMP,
        FMT_BR_REG, FMT_BR_IMM, FMT_DIFF, FMT_ILLEGAL
    } fmt_e;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] func;
        fmt_e       fmt;
    } enc_info_t;

    function automatic enc_info_t mnem_info(input logic [4:0] m);
        enc_info_t i;
        i = '{op: 6'd0, func: 6'd0, fmt: FMT_ILLEGAL};
        case (m)
            MN_ADD:   i = '{op: OP_ALU,    func: FN_ADD,  fmt: FMT_R};
            MN_COMP:  i = '{op: OP_ALU,    func: FN_COMP, fmt: FMT_R};
            MN_ADDI:  i = '{op: OP_ALUI,   func: FN_ADD,  fmt: FMT_I_ARITH};
            MN_COMPI: i = '{op: OP_ALUI,   func: FN_COMP, fmt: FMT_I_ARITH};
            MN_AND:   i = '{op: OP_LOGIC,  func: FN_AND,  fmt: FMT_R};
            MN_XOR:   i = '{op: OP_LOGIC,  func: FN_XOR,  fmt: FMT_R};
            MN_SHLL:  i = '{op: OP_SHIFT,  func: FN_SLL,  fmt: FMT_R};
            MN_SHRL:  i = '{op: OP_SHIFT,  func: FN_SRL,  fmt: FMT_R};
            MN_SHRA:  i = '{op: OP_SHIFT,  func: FN_SRA,  fmt: FMT_R};
            MN_SHLLV: i = '{op: OP_SHIFTV, func: FN_SLL,  fmt: FMT_R};
            MN_SHRLV: i = '{op: OP_SHIFTV, func: FN_SRL,  fmt: FMT_R};
            MN_SHRAV: i = '{op: OP_SHIFTV, func: FN_SRA,  fmt: FMT_R};
            MN_LW:    i = '{op: OP_LW,     func: 6'd0,    fmt: FMT_MEM};
            MN_SW:    i = '{op: OP_SW,     func: 6'd0,    fmt: FMT_MEM};
            MN_B:     i = '{op: OP_B,      func: 6'd0,    fmt: FMT_JUMP};
            MN_BL:    i = '{op: OP_BL,     func: 6'd0,    fmt: FMT_JUMP};
            MN_BCY:   i = '{op: OP_BCY,    func: 6'd0,    fmt: FMT_JUMP};
            MN_BNCY:  i = '{op: OP_BNCY,   func: 6'd0,    fmt: FMT_JUMP};
            MN_BR:    i = '{op: OP_BR,     func: 6'd0,    fmt: FMT_BR_REG};
            MN_BLTZ:  i = '{op: OP_BLTZ,   func: 6'd0,    fmt: FMT_BR_IMM};
            MN_BZ:    i = '{op: OP_BZ,     func: 6'd0,    fmt: FMT_BR_IMM};
            MN_BNZ:   i = '{op: OP_BNZ,    func: 6'd0,    fmt: FMT_BR_IMM};
            MN_DIFF:  i = '{op: OP_DIFF,   func: 6'd0,    fmt: FMT_DIFF};
            default:  i = '{op: 6'd0,      func: 6'd0,    fmt: FMT_ILLEGAL};
        endcase
        return i;
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational packer: symbolic instruction fields to a 32-bit KGP-miniRISC word,
// with illegal-mnemonic and imm16 sign-range flags.
module instr_field_encoder
    import kgp_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_bad
);

    enc_info_t info;
    logic      imm16_fmt;

    always_comb begin
        info      = mnem_info(mnem);
        word      = 32'(info.op) << OP_LSB;
        imm16_fmt = 1'b0;
        case (info.fmt)
            FMT_R:       word = word | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                                     | (32'(shamt) << SHAMT_LSB) | 32'(info.func);
            FMT_I_ARITH: begin
                word = word | (32'(rs) << RS_LSB) | (32'(info.func[4:0]) << RT_LSB)
                            | 32'(imm[15:0]);
                imm16_fmt = 1'b1;
            end
            FMT_MEM: begin
                word = word | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm[15:0]);
                imm16_fmt = 1'b1;
            end
            FMT_JUMP:    word = word | 32'(imm);
            FMT_BR_REG:  word = word | (32'(rs) << RS_LSB);
            FMT_BR_IMM: begin
                word = word | (32'(rs) << RS_LSB) | 32'(imm[15:0]);
                imm16_fmt = 1'b1;
            end
            FMT_DIFF:    word = word | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB);
            default:     word = 32'd0;
        endcase
        illegal   = (info.fmt == FMT_ILLEGAL);
        // imm16 must be a sign-extension of bit 15 across the unused upper bits
        range_bad = imm16_fmt && (imm[25:16] != {10{imm[15]}});
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions and writes them sequentially into IMEM from a base address.
// Define ENC_RANGE_CHECK_EN to reject out-of-range imm16 values (sets err_range, no write).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | in_ready high, waiting for an instruction
// WRITE | imem_we high for one cycle, pointer advances
// DONE  | session finished; done held until next start
module instr_encoder_loader
    import kgp_isa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic              err_illegal,
    output logic              err_range,
    output logic              err_overflow
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_e;

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [CW-1:0]     num_q;
    logic [CW-1:0]     ww_next;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              range_reject;

`ifdef ENC_RANGE_CHECK_EN
    logic enc_range_bad;
    assign range_reject = enc_range_bad;
`else
    logic enc_range_bad_unused;
    assign range_reject = 1'b0;
`endif

    instr_field_encoder u_enc (
        .mnem      (in_mnem),
        .rs        (in_rs),
        .rt        (in_rt),
        .shamt     (in_shamt),
        .imm       (in_imm),
        .word      (enc_word),
        .illegal   (enc_illegal),
`ifdef ENC_RANGE_CHECK_EN
        .range_bad (enc_range_bad)
`else
        .range_bad (enc_range_bad_unused)
`endif
    );

    assign ww_next = words_written + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            num_q         <= '0;
            in_ready      <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            err_illegal   <= 1'b0;
            err_range     <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ptr           <= base_addr;
                        num_q         <= num_words;
                        words_written <= '0;
                        err_illegal   <= 1'b0;
                        err_range     <= 1'b0;
                        err_overflow  <= 1'b0;
                        if (num_words == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= S_LOAD;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (enc_illegal) begin
                            err_illegal <= 1'b1;
                        end else if (range_reject) begin
                            err_range <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ptr;
                            imem_wdata <= enc_word;
                            in_ready   <= 1'b0;
                            state      <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    imem_we       <= 1'b0;
                    ptr           <= ptr + ADDR_W'(1);
                    words_written <= ww_next;
                    if (ww_next == num_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (ptr == '1) begin
                        // last address consumed with words still pending: no wrap
                        err_overflow <= 1'b1;
                        state        <= S_DONE;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of single-word sessions plus
// hand-written multi-cycle sequences (illegal, back-to-back, range, overflow, abort).
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   num_words = '0;
    logic              in_valid = 1'b0;
    logic [4:0]        in_mnem = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_shamt = '0;
    logic [25:0]       in_imm = '0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;
    logic              err_illegal;
    logic              err_range;
    logic              err_overflow;

    int n_pass = 0;
    int n_total = 0;
    int we_cnt = 0;
    int exp_we = 0;

    typedef struct {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [25:0] imm;
        logic [9:0]  base;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mnem       (in_mnem),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_shamt      (in_shamt),
        .in_imm        (in_imm),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .err_illegal   (err_illegal),
        .err_range     (err_range),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we) we_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session(input logic [9:0] b, input logic [10:0] n);
        base_addr = b;
        num_words = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] sh, input logic [25:0] imm);
        in_mnem = m; in_rs = rs; in_rt = rt; in_shamt = sh; in_imm = imm;
        in_valid = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {31'd0, in_ready | imem_we | busy | done | err_illegal
                             | err_range | err_overflow}, 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_ww"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        // mnem codes: add0 comp1 addi2 compi3 and4 xor5 shll6 shrl7 shra8 shllv9 ... lw12 b14 bncy17 br18 bz20 diff22
        vecs[0] = '{5'd0,  5'd3,  5'd5, 5'd0, 26'h0,       10'h000, 32'h0065_0000};
        vecs[1] = '{5'd8,  5'd2,  5'd0, 5'd4, 26'h0,       10'h010, 32'h5040_2002};
        vecs[2] = '{5'd2,  5'd4,  5'd0, 5'd0, 26'h3FFFFFF, 10'h020, 32'h0480_FFFF};
        vecs[3] = '{5'd3,  5'd1,  5'd0, 5'd0, 26'h5,       10'h021, 32'h0421_0005};
        vecs[4] = '{5'd5,  5'd7,  5'd8, 5'd0, 26'h0,       10'h100, 32'h28E8_0001};
        vecs[5] = '{5'd18, 5'd31, 5'd5, 5'd0, 26'h0,       10'h1FF, 32'hB3E0_0000};
        vecs[6] = '{5'd22, 5'd1,  5'd2, 5'd3, 26'h55,      10'h002, 32'hC822_0000};
        vecs[7] = '{5'd20, 5'd6,  5'd0, 5'd0, 26'h10,      10'h003, 32'hB8C0_0010};
        vecs[8] = '{5'd17, 5'd0,  5'd0, 5'd0, 26'h3FFFFFF, 10'h004, 32'hAFFF_FFFF};
        vecs[9] = '{5'd9,  5'd1,  5'd2, 5'd0, 26'h0,       10'h005, 32'h5422_0000};

        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            begin_session(vecs[i].base, 11'd1);
            chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, 32'd1);
            drive(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].shamt, vecs[i].imm);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_we", i), {31'd0, imem_we}, 32'd1);
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].base));
            chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].exp);
            chk($sformatf("v%0d_ready_wr", i), {31'd0, in_ready}, 32'd0);
            exp_we++;
            step();
            chk($sformatf("v%0d_done", i), {30'd0, done, busy}, 32'd2);
            chk($sformatf("v%0d_ww", i), 32'(words_written), 32'd1);
            chk($sformatf("v%0d_we_off", i), {31'd0, imem_we}, 32'd0);
        end

        // illegal mnemonic: no write, counter unchanged, next word at same address
        begin_session(10'd5, 11'd1);
        drive(5'd31, 5'd1, 5'd1, 5'd0, 26'h0);
        step();
        chk("ill_flag", {31'd0, err_illegal}, 32'd1);
        chk("ill_no_we", {31'd0, imem_we}, 32'd0);
        chk("ill_ww", 32'(words_written), 32'd0);
        chk("ill_ready", {31'd0, in_ready}, 32'd1);
        drive(5'd0, 5'd3, 5'd5, 5'd0, 26'h0);
        step();
        in_valid = 1'b0;
        chk("ill_next_addr", 32'(imem_addr), 32'd5);
        chk("ill_next_wdata", imem_wdata, 32'h0065_0000);
        exp_we++;
        step();
        chk("ill_done_sticky", {30'd0, done, err_illegal}, 32'd3);

        // lw then b, back to back
        begin_session(10'd0, 11'd2);
        chk("lwb_err_cleared", {31'd0, err_illegal}, 32'd0);
        drive(5'd12, 5'd1, 5'd2, 5'd0, 26'h3FFFFFC);
        step();
        chk("lwb_w0_addr", 32'(imem_addr), 32'd0);
        chk("lwb_w0_wdata", imem_wdata, 32'h7822_FFFC);
        chk("lwb_w0_ready", {30'd0, in_ready, imem_we}, 32'd1);
        exp_we++;
        drive(5'd14, 5'd0, 5'd0, 5'd0, 26'h100);
        step();
        chk("lwb_load_ready", {30'd0, in_ready, imem_we}, 32'd2);
        chk("lwb_ww1", 32'(words_written), 32'd1);
        step();
        in_valid = 1'b0;
        chk("lwb_w1_addr", 32'(imem_addr), 32'd1);
        chk("lwb_w1_wdata", imem_wdata, 32'hA000_0100);
        chk("lwb_w1_ready", {30'd0, in_ready, imem_we}, 32'd1);
        exp_we++;
        step();
        chk("lwb_done", {30'd0, done, busy}, 32'd2);
        chk("lwb_ww2", 32'(words_written), 32'd2);

        // addi with imm outside the signed 16-bit range
        begin_session(10'd40, 11'd1);
        drive(5'd2, 5'd0, 5'd0, 5'd0, 26'h10000);
        step();
`ifdef ENC_RANGE_CHECK_EN
        chk("rng_flag", {30'd0, err_range, imem_we}, 32'd2);
        drive(5'd0, 5'd1, 5'd1, 5'd0, 26'h0);
        step();
        chk("rng_next_wdata", imem_wdata, 32'h0021_0000);
`else
        chk("rng_flag", {30'd0, err_range, imem_we}, 32'd1);
        chk("rng_trunc_wdata", imem_wdata, 32'h0400_0000);
`endif
        in_valid = 1'b0;
        chk("rng_addr", 32'(imem_addr), 32'd40);
        exp_we++;
        step();
        chk("rng_done", {31'd0, done}, 32'd1);

        // overflow at the top address
        begin_session(10'h3FF, 11'd2);
        drive(5'd0, 5'd3, 5'd5, 5'd0, 26'h0);
        step();
        in_valid = 1'b0;
        chk("ovf_addr", 32'(imem_addr), 32'h3FF);
        chk("ovf_we", {31'd0, imem_we}, 32'd1);
        exp_we++;
        step();
        chk("ovf_flags", {28'd0, err_overflow, done, busy, in_ready}, 32'hC);
        chk("ovf_ww", 32'(words_written), 32'd1);
        step();
        chk("ovf_no_more_we", {31'd0, imem_we}, 32'd0);

        // zero-length session goes straight to done
        begin_session(10'd7, 11'd0);
        chk("zero_flags", {29'd0, done, busy, in_ready}, 32'd4);
        chk("zero_ww", 32'(words_written), 32'd0);

        // start while busy is ignored, then reset during WRITE aborts
        begin_session(10'd0, 11'd3);
        base_addr = 10'd100;
        num_words = 11'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_ign", {30'd0, busy, in_ready}, 32'd3);
        drive(5'd0, 5'd3, 5'd5, 5'd0, 26'h0);
        step();
        chk("abort_pre_addr", 32'(imem_addr), 32'd0);
        chk("abort_pre_we", {31'd0, imem_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        step();
        step();
        chk("abort_hold_we", {31'd0, imem_we}, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        chk("abort_idle", {30'd0, busy, in_ready}, 32'd0);

        chk("we_count", 32'(we_cnt), 32'(exp_we));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
